operand_sequencer: RTL and testbench
====================================

# operand_sequencer

Parametrised control sequencer for the operand/operation datapath. It loads `NUM_OPERANDS` operand registers through one-hot load strobes and waits for `start`. It then runs a one-cycle validation, enables the operation unit until `done`, and reports ready or a coded error. Compared with the fixed two-operand control unit it adds:
- configurable operand count;
- a RUN timeout;
- an abort input;
- an error code;
- an operand counter.

## Interface
- `NUM_OPERANDS`, 2: operands loaded per operation; legal range 1..8.
- `TIMEOUT`, 255: maximum RUN cycles without `done`; 0 disables the timeout.
- `IDX_W` (localparam) = $clog2(NUM_OPERANDS+1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `load` in 1: operand strobe; one operand per sampled high cycle.
- `start` in 1: begin validation; used in WAIT only.
- `abort` in 1: cancel the operation in progress.
- `done` in 1: operation-unit completion; used in RUN only.
- `error` in 1: validation result; sampled in VALIDATE only.
- `load_en` out NUM_OPERANDS: one-hot operand register load enable.
- `val` out 1: validation enable.
- `op_en` out 1: operation-unit enable.
- `ready` out 1: result valid.
- `error_out` out 1: error state indicator.
- `err_code` out 2: 0 none, 1 validation, 2 timeout, 3 abort.
- `op_idx` out IDX_W: number of operands loaded in the current sequence.
- `busy` out 1: sequence in progress.

## Operation
- States: IDLE, LOAD, WAIT, VALIDATE, RUN, READY, ERROR. A single clocked state register; no latches, no combinational state feedback.
- IDLE/READY/ERROR + `load`:
  - `load_en[0]`=1, `op_idx`=1, `err_code`=0.
  - Next state is LOAD, or WAIT if `NUM_OPERANDS`==1.
- LOAD + `load`:
  - `load_en[op_idx]`=1, `op_idx`++.
  - When `op_idx` reaches `NUM_OPERANDS`, go to WAIT.
  - `load`=0 holds the state.
- WAIT: `start` moves to VALIDATE; `load` is ignored.
- VALIDATE lasts one cycle with `val`=1.
  - `error`=1 moves to ERROR with `err_code`=1.
  - Otherwise move to RUN.
- RUN: `op_en`=1 and the timer counts RUN cycles from 0.
  - `done`=1 moves to READY.
  - With `TIMEOUT`≠0 and the timer at `TIMEOUT`-1 with no `done`, move to ERROR with `err_code`=2.
- READY: `ready`=1; hold until `load`.
- ERROR: `error_out`=1 and `err_code` is held until a `load` leaves ERROR.
- `abort`=1 in LOAD, WAIT, VALIDATE or RUN moves to ERROR with `err_code`=3. `abort` is ignored in IDLE, READY and ERROR.
- `busy`=1 in LOAD, WAIT, VALIDATE and RUN.
- Inputs that are not used in the current state are ignored (`start`, `done`, `error`).

## Timing
- Reset (`rst`=0, any time including mid-RUN):
  - State goes to IDLE.
  - All outputs go to 0, including `load_en`, `op_idx`, `err_code` and the timer.
  - Takes effect immediately, without waiting for `clk`.
- All outputs are registered and change only on a `clk` rising edge.
- `load` sampled at edge N gives `load_en` high for exactly the cycle after edge N.
  - Back-to-back `load` cycles load consecutive operands, one per cycle.
- `val`, `op_en`, `ready` and `error_out` are asserted for exactly the cycles spent in VALIDATE, RUN, READY and ERROR respectively.
- Minimum latency, `start` sampled to `op_en` high: 2 edges (`start` → VALIDATE → RUN).
- A `done` sampled on RUN's first cycle gives `ready` in the next cycle.
- Simultaneous events:
  - `abort` beats `done`, timeout and `error`.
  - `done` beats timeout on the same edge.
  - `start` together with `load` in WAIT: `start` wins and `load` is dropped.
- With `TIMEOUT`=T, RUN lasts at most T cycles; the timer is cleared on every entry to RUN.

## Structure
- Package `seq_pkg`: state enum `seq_state_t` (logic [2:0]) and error enum `err_code_t` (`ERR_NONE`, `ERR_VAL`, `ERR_TIMEOUT`, `ERR_ABORT`).
- Sub-module `run_timer`: clear/enable up-counter with terminal-count flag, parametrised by `TIMEOUT`.
  - Instantiated once.
  - Terminal count is tied off when `TIMEOUT`=0.
- The top level holds the FSM, the `op_idx` counter and the output registers.

## Test plan
- Reset mid-RUN (`NUM_OPERANDS`=2): assert `rst`=0 → all outputs 0 and state IDLE immediately, with no `clk` edge needed.
- `NUM_OPERANDS`=3, three back-to-back `load` cycles:
  - `load_en` gives 001, 010, 100 on consecutive cycles.
  - `op_idx` counts 1, 2, 3; state is WAIT.
- Normal run, `TIMEOUT`=255:
  - `start` gives one `val` cycle, then `op_en` high.
  - `done` on RUN cycle 5 gives `ready`=1, `op_en`=0, `err_code`=0.
- Validation fail: `error`=1 during VALIDATE → `error_out`=1, `err_code`=1. A following `load` gives `load_en[0]`=1 and `err_code`=0.
- Timeout, `TIMEOUT`=4:
  - With no `done`, `op_en` is high for exactly 4 cycles, then `err_code`=2.
  - Repeat with `done` on cycle 4 → READY.
- Abort same edge as `done` in RUN → ERROR with `err_code`=3. `abort` in IDLE → no change.

Source files
------------

// File: rtl/operand_sequencer_pkg.sv
// seq_pkg: shared types for the operand sequencer.
//   seq_state_t - FSM state encoding (IDLE is the all-zero reset encoding)
//   err_code_t  - error code reported on err_code
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT     = 3'd2,
    ST_VALIDATE = 3'd3,
    ST_RUN      = 3'd4,
    ST_READY    = 3'd5,
    ST_ERROR    = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_VAL     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_code_t;

endpackage

// File: rtl/operand_sequencer_if.sv
// operand_sequencer_if: control handshake between the sequencer and its
// surroundings.
//   inputs to the sequencer : load, start, abort, done, error
//   outputs of the sequencer: load_en[NUM_OPERANDS], val, op_en, ready,
//                             error_out, err_code, op_idx[IDX_W], busy
//   modport slave  - the sequencer side
//   modport master - the side driving commands and observing status
interface operand_sequencer_if
  import seq_pkg::*;
#(
  parameter int NUM_OPERANDS = 2
);

  localparam int IDX_W = $clog2(NUM_OPERANDS + 1);

  logic                    load;
  logic                    start;
  logic                    abort;
  logic                    done;
  logic                    error;
  logic [NUM_OPERANDS-1:0] load_en;
  logic                    val;
  logic                    op_en;
  logic                    ready;
  logic                    error_out;
  err_code_t               err_code;
  logic [IDX_W-1:0]        op_idx;
  logic                    busy;

  modport slave (
    input  load, start, abort, done, error,
    output load_en, val, op_en, ready, error_out, err_code, op_idx, busy
  );

  modport master (
    output load, start, abort, done, error,
    input  load_en, val, op_en, ready, error_out, err_code, op_idx, busy
  );

endinterface

// File: rtl/operand_sequencer_run_timer.sv
// run_timer: counts cycles while enabled, cleared whenever clear is high.
// tc flags the cycle in which the count equals TIMEOUT-1; with TIMEOUT=0
// tc is tied low so the run never times out.
//   clk, rst (async active-low), clear, enable -> tc
module run_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  // Count only needs to reach TIMEOUT-1 before the run is forced out.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // Cycle counter: async reset, clear has priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign tc = 1'b0;
    end else begin : g_timeout
      assign tc = enable && (count == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: loads NUM_OPERANDS operands via one-hot load strobes,
// waits for start, validates for one cycle, enables the operation unit until
// done (or timeout/abort) and reports ready or an error code.
//   clk, rst (async active-low)
//   bus (slave): load/start/abort/done/error in;
//                load_en/val/op_en/ready/error_out/err_code/op_idx/busy out
// All outputs are registered copies of the next-state decode, so they track
// the state register cycle for cycle.
module operand_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_OPERANDS = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  operand_sequencer_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_OPERANDS + 1);

  seq_state_t              state;
  seq_state_t              state_next;
  logic [NUM_OPERANDS-1:0] load_en;
  logic [NUM_OPERANDS-1:0] load_en_next;
  logic [IDX_W-1:0]        op_idx;
  logic [IDX_W-1:0]        op_idx_next;
  logic [IDX_W-1:0]        op_idx_inc;
  err_code_t               err_code;
  err_code_t               err_code_next;
  logic                    val;
  logic                    op_en;
  logic                    ready;
  logic                    error_out;
  logic                    busy;
  logic                    timer_tc;

  assign op_idx_inc = op_idx + IDX_W'(1);

  // Timer restarts at 0 on every RUN entry because it is held clear elsewhere.
  run_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_RUN),
    .enable (state == ST_RUN),
    .tc     (timer_tc)
  );

  // Next-state, next-strobe, operand counter and error code decode.
  always_comb begin
    state_next    = state;
    load_en_next  = '0;
    op_idx_next   = op_idx;
    err_code_next = err_code;
    case (state)
      ST_IDLE, ST_READY, ST_ERROR: begin
        if (bus.load) begin
          load_en_next  = NUM_OPERANDS'(1);
          op_idx_next   = IDX_W'(1);
          err_code_next = ERR_NONE;
          state_next    = (NUM_OPERANDS == 1) ? ST_WAIT : ST_LOAD;
        end else begin
          state_next = state;
        end
      end
      ST_LOAD: begin
        if (bus.abort) begin
          err_code_next = ERR_ABORT;
          state_next    = ST_ERROR;
        end else if (bus.load) begin
          load_en_next = NUM_OPERANDS'(1) << op_idx;
          op_idx_next  = op_idx_inc;
          state_next   = (op_idx_inc == IDX_W'(NUM_OPERANDS)) ? ST_WAIT : ST_LOAD;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_WAIT: begin
        // load is deliberately ignored here, even alongside start.
        if (bus.abort) begin
          err_code_next = ERR_ABORT;
          state_next    = ST_ERROR;
        end else if (bus.start) begin
          state_next = ST_VALIDATE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_VALIDATE: begin
        if (bus.abort) begin
          err_code_next = ERR_ABORT;
          state_next    = ST_ERROR;
        end else if (bus.error) begin
          err_code_next = ERR_VAL;
          state_next    = ST_ERROR;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Priority: abort, then done, then timeout.
        if (bus.abort) begin
          err_code_next = ERR_ABORT;
          state_next    = ST_ERROR;
        end else if (bus.done) begin
          state_next = ST_READY;
        end else if (timer_tc) begin
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_ERROR;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        op_idx_next   = '0;
        err_code_next = ERR_NONE;
      end
    endcase
  end

  // State and registered outputs; outputs decode the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      load_en   <= '0;
      op_idx    <= '0;
      err_code  <= ERR_NONE;
      val       <= 1'b0;
      op_en     <= 1'b0;
      ready     <= 1'b0;
      error_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      load_en   <= load_en_next;
      op_idx    <= op_idx_next;
      err_code  <= err_code_next;
      val       <= (state_next == ST_VALIDATE);
      op_en     <= (state_next == ST_RUN);
      ready     <= (state_next == ST_READY);
      error_out <= (state_next == ST_ERROR);
      busy      <= (state_next == ST_LOAD) || (state_next == ST_WAIT) ||
                   (state_next == ST_VALIDATE) || (state_next == ST_RUN);
    end
  end

  assign bus.load_en   = load_en;
  assign bus.op_idx    = op_idx;
  assign bus.err_code  = err_code;
  assign bus.val       = val;
  assign bus.op_en     = op_en;
  assign bus.ready     = ready;
  assign bus.error_out = error_out;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: scoreboard bench for operand_sequencer.
// Two instances: A (NUM_OPERANDS=3, TIMEOUT=255) and B (NUM_OPERANDS=2,
// TIMEOUT=4). Each step drives inputs on the falling edge, pushes the
// hand-derived expected outputs, then pops and compares just after the
// rising edge.
module tb_operand_sequencer;

  typedef struct packed {
    logic [7:0] le;
    logic [3:0] idx;
    logic [1:0] code;
    logic [4:0] fl;   // {val, op_en, ready, error_out, busy}
  } exp_t;

  localparam logic [4:0] I_NONE  = 5'b00000;
  localparam logic [4:0] I_LOAD  = 5'b10000;
  localparam logic [4:0] I_START = 5'b01000;
  localparam logic [4:0] I_ABORT = 5'b00100;
  localparam logic [4:0] I_DONE  = 5'b00010;
  localparam logic [4:0] I_ERR   = 5'b00001;

  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_BUSY = 5'b00001;
  localparam logic [4:0] F_VAL  = 5'b10001;
  localparam logic [4:0] F_RUN  = 5'b01001;
  localparam logic [4:0] F_RDY  = 5'b00100;
  localparam logic [4:0] F_ERR  = 5'b00010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sel = 0;
  int   stepn = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  operand_sequencer_if #(.NUM_OPERANDS(3)) bus_a ();
  operand_sequencer_if #(.NUM_OPERANDS(2)) bus_b ();

  operand_sequencer #(.NUM_OPERANDS(3), .TIMEOUT(255)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  operand_sequencer #(.NUM_OPERANDS(2), .TIMEOUT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    if (sel == 0) begin
      o.le   = 8'(bus_a.load_en);
      o.idx  = 4'(bus_a.op_idx);
      o.code = bus_a.err_code;
      o.fl   = {bus_a.val, bus_a.op_en, bus_a.ready, bus_a.error_out, bus_a.busy};
    end else begin
      o.le   = 8'(bus_b.load_en);
      o.idx  = 4'(bus_b.op_idx);
      o.code = bus_b.err_code;
      o.fl   = {bus_b.val, bus_b.op_en, bus_b.ready, bus_b.error_out, bus_b.busy};
    end
    return o;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    exp_t o;
    o = observe();
    check_value($sformatf("%s_load_en", tag), int'(o.le), int'(e.le));
    check_value($sformatf("%s_op_idx", tag), int'(o.idx), int'(e.idx));
    check_value($sformatf("%s_err_code", tag), int'(o.code), int'(e.code));
    check_value($sformatf("%s_flags", tag), int'(o.fl), int'(e.fl));
  endtask

  task automatic drive(input logic [4:0] in);
    logic [4:0] a_in;
    logic [4:0] b_in;
    a_in = (sel == 0) ? in : I_NONE;
    b_in = (sel == 1) ? in : I_NONE;
    {bus_a.load, bus_a.start, bus_a.abort, bus_a.done, bus_a.error} = a_in;
    {bus_b.load, bus_b.start, bus_b.abort, bus_b.done, bus_b.error} = b_in;
  endtask

  // One clock: drive, push expectation, sample after the edge, pop, compare.
  task automatic step(input logic [4:0] in, input logic [7:0] le,
                      input logic [3:0] idx, input logic [1:0] code,
                      input logic [4:0] fl);
    exp_t e;
    @(negedge clk);
    drive(in);
    stepn++;
    e.le = le; e.idx = idx; e.code = code; e.fl = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_value("sb_underflow", 0, 1);
    end else begin
      compare($sformatf("%c%0d", (sel == 0) ? "a" : "b", stepn), sb.pop_front());
    end
  endtask

  task automatic check_zero(input string tag);
    compare(tag, '0);
  endtask

  initial begin
    drive(I_NONE);
    #1 rst = 1'b0;
    #1;
    sel = 0; check_zero("reset_a");
    sel = 1; check_zero("reset_b");
    @(negedge clk);
    rst = 1'b1;

    // ---------------- instance A: 3 operands, TIMEOUT 255 ----------------
    sel = 0;
    step(I_LOAD,           8'h01, 4'd1, 2'd0, F_BUSY);
    step(I_LOAD,           8'h02, 4'd2, 2'd0, F_BUSY);
    step(I_LOAD,           8'h04, 4'd3, 2'd0, F_BUSY);   // WAIT
    step(I_LOAD,           8'h00, 4'd3, 2'd0, F_BUSY);   // load ignored in WAIT
    step(I_START,          8'h00, 4'd3, 2'd0, F_VAL);
    step(I_NONE,           8'h00, 4'd3, 2'd0, F_RUN);    // RUN cycle 1
    for (int i = 0; i < 4; i++) begin
      step(I_ERR,          8'h00, 4'd3, 2'd0, F_RUN);    // error ignored in RUN
    end
    step(I_DONE,           8'h00, 4'd3, 2'd0, F_RDY);    // done in cycle 5
    step(I_NONE,           8'h00, 4'd3, 2'd0, F_RDY);
    step(I_ABORT,          8'h00, 4'd3, 2'd0, F_RDY);    // abort ignored
    // validation failure, start+load in WAIT
    step(I_LOAD,           8'h01, 4'd1, 2'd0, F_BUSY);
    step(I_NONE,           8'h00, 4'd1, 2'd0, F_BUSY);   // LOAD holds
    step(I_LOAD,           8'h02, 4'd2, 2'd0, F_BUSY);
    step(I_LOAD,           8'h04, 4'd3, 2'd0, F_BUSY);
    step(I_START | I_LOAD, 8'h00, 4'd3, 2'd0, F_VAL);
    step(I_ERR,            8'h00, 4'd3, 2'd1, F_ERR);
    step(I_DONE,           8'h00, 4'd3, 2'd1, F_ERR);
    step(I_LOAD,           8'h01, 4'd1, 2'd0, F_BUSY);
    step(I_ABORT,          8'h00, 4'd1, 2'd3, F_ERR);    // abort in LOAD
    // abort on same edge as done in RUN
    step(I_LOAD,           8'h01, 4'd1, 2'd0, F_BUSY);
    step(I_LOAD,           8'h02, 4'd2, 2'd0, F_BUSY);
    step(I_LOAD,           8'h04, 4'd3, 2'd0, F_BUSY);
    step(I_START,          8'h00, 4'd3, 2'd0, F_VAL);
    step(I_NONE,           8'h00, 4'd3, 2'd0, F_RUN);
    step(I_ABORT | I_DONE, 8'h00, 4'd3, 2'd3, F_ERR);

    // ---------------- instance B: 2 operands, TIMEOUT 4 ----------------
    sel = 1;
    step(I_ABORT,          8'h00, 4'd0, 2'd0, F_IDLE);   // abort in IDLE
    step(I_LOAD,           8'h01, 4'd1, 2'd0, F_BUSY);
    step(I_LOAD,           8'h02, 4'd2, 2'd0, F_BUSY);
    step(I_START,          8'h00, 4'd2, 2'd0, F_VAL);
    for (int i = 0; i < 4; i++) begin
      step(I_NONE,         8'h00, 4'd2, 2'd0, F_RUN);    // RUN cycles 1..4
    end
    step(I_NONE,           8'h00, 4'd2, 2'd2, F_ERR);    // timeout
    // done on the terminal cycle beats timeout
    step(I_LOAD,           8'h01, 4'd1, 2'd0, F_BUSY);
    step(I_LOAD,           8'h02, 4'd2, 2'd0, F_BUSY);
    step(I_START,          8'h00, 4'd2, 2'd0, F_VAL);
    for (int i = 0; i < 3; i++) begin
      step(I_NONE,         8'h00, 4'd2, 2'd0, F_RUN);    // RUN cycles 1..3
    end
    step(I_NONE,           8'h00, 4'd2, 2'd0, F_RUN);    // RUN cycle 4
    step(I_DONE,           8'h00, 4'd2, 2'd0, F_RDY);
    // asynchronous reset in the middle of RUN
    step(I_LOAD,           8'h01, 4'd1, 2'd0, F_BUSY);
    step(I_LOAD,           8'h02, 4'd2, 2'd0, F_BUSY);
    step(I_START,          8'h00, 4'd2, 2'd0, F_VAL);
    step(I_NONE,           8'h00, 4'd2, 2'd0, F_RUN);
    rst = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b1;
    // timer restarted by reset: a fresh run still lasts four cycles
    step(I_LOAD,           8'h01, 4'd1, 2'd0, F_BUSY);
    step(I_LOAD,           8'h02, 4'd2, 2'd0, F_BUSY);
    step(I_START,          8'h00, 4'd2, 2'd0, F_VAL);
    for (int i = 0; i < 4; i++) begin
      step(I_NONE,         8'h00, 4'd2, 2'd0, F_RUN);
    end
    step(I_NONE,           8'h00, 4'd2, 2'd2, F_ERR);

    drive(I_NONE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
